iter_divider: RTL
=================

// Module: iter_divider
// PURPOSE
//  Multi-cycle radix-2 restoring divider; responder side of the AXI-stream divider handshake that exe_stage drives.
//  Drop-in for the unsigned_divider/signed_divider instances in exe_stage: same port names, same result packing.
//  One instance per signedness (SIGNED=0 for DIVU, SIGNED=1 for DIV); one division in flight at a time.
// PARAMETERS
//  SIGNED   0   1: two's-complement operands/results; 0: unsigned
//  DATA_W   32  operand width; dout width is 2*DATA_W
// PORTS
//  clk                     in   1        clock
//  reset                   in   1        synchronous, active-high
//  s_axis_dividend_tdata   in   DATA_W   dividend
//  s_axis_dividend_tvalid  in   1        dividend valid
//  s_axis_dividend_tready  out  1        dividend accepted when valid&ready
//  s_axis_divisor_tdata    in   DATA_W   divisor
//  s_axis_divisor_tvalid   in   1        divisor valid
//  s_axis_divisor_tready   out  1        divisor accepted when valid&ready
//  m_axis_dout_tdata       out  2*DATA_W {quotient, remainder}: [63:32]=quotient, [31:0]=remainder
//  m_axis_dout_tvalid      out  1        one-cycle result pulse; no back-pressure
// BEHAVIOUR
//  Reset: state=IDLE, both captured flags=0, both tready=1, dout_tvalid=0, dout_tdata=0. Reset mid-division aborts it; no result pulse.
//  States: IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: dividend_tready=!have_dvd, divisor_tready=!have_dvs. Channels independent, any order, same cycle allowed.
//    Handshake latches tdata, sets have_* flag; an operand is never re-accepted until the result pulse.
//    When the last missing operand handshakes in cycle c: IDLE->BUSY at c+1; flags cleared.
//  BUSY: both tready=0. 32 iterations, one quotient bit per cycle, counter 0..31; cnt==31 -> DONE.
//    Step: rem' = {rem[30:0], q[31]}; q' = {q[30:0], ~borrow}; subtract |divisor| if no borrow (33-bit subtract).
//  DONE: both tready=0; dout_tvalid=1 for exactly this cycle (c+33); dout_tdata updated at DONE entry, holds after.
//    DONE->IDLE next cycle; tready reasserts at c+34. Back-to-back throughput: one result per 34 cycles.
//  Signed (SIGNED=1): divide magnitudes; quotient negated if sign(dvd)^sign(dvs); remainder takes sign of dividend.
//    0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0 (wrap, no trap).
//  Divide by zero (divisor==0, either mode): q=0xFFFFFFFF, r=dividend unchanged; same 33-cycle latency.
//  Operand tdata changes after handshake have no effect; tvalid deassertion while tready=0 is legal.
//  Identities for all non-zero divisors: dividend == q*divisor + r, |r| < |divisor|, r==0 or sign(r)==sign(dividend).
// TESTING
//  T1 U: dvd=100, dvs=7 same cycle c -> tvalid only at c+33, tdata={32'd14,32'd2}; tready low c+1..c+33.
//  T2 S: dvd=-7 (0xFFFFFFF9), dvs=2 -> {0xFFFFFFFD, 0xFFFFFFFF}; dvd=7,dvs=-2 -> {0xFFFFFFFD, 0x00000001}.
//  T3 Split order: divisor=3 at cycle 5, dividend=10 at cycle 9 (divisor_tready=0 cycles 6-9) -> {3,1} at cycle 42.
//  T4 Corners: dvs=0, dvd=0x1234 -> {0xFFFFFFFF,0x1234}; S: 0x80000000/-1 -> {0x80000000,0}; U: 0xFFFFFFFF/1 -> {0xFFFFFFFF,0}.
//  T5 reset at BUSY cycle 10 -> no tvalid for 40 cycles; both tready=1 next cycle; new 9/3 -> {3,0} after 33 cycles.
//  T6 Random 10k pairs, both modes, random valid gaps -> matches $signed/unsigned / and %; one pulse per request.

Source files
------------

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring divider, one quotient bit per cycle,
// AXI-stream style operand handshake and a single-cycle {quotient, remainder} result pulse.
module iter_divider #(
    parameter int SIGNED = 0,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     s_axis_dividend_tdata,
    input  logic                  s_axis_dividend_tvalid,
    output logic                  s_axis_dividend_tready,
    input  logic [DATA_W-1:0]     s_axis_divisor_tdata,
    input  logic                  s_axis_divisor_tvalid,
    output logic                  s_axis_divisor_tready,
    output logic [2*DATA_W-1:0]   m_axis_dout_tdata,
    output logic                  m_axis_dout_tvalid
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    localparam int CW = $clog2(DATA_W);
    logic [1:0] state;
    logic have_dvd, have_dvs;
    logic [DATA_W-1:0] dvd_r, dvs_r, q, rem;
    logic [CW-1:0] cnt;
    logic dvd_hs, dvs_hs, start, last, borrow, neg_dvd, neg_dvs, neg_in, dvs_zero;
    logic [DATA_W-1:0] dvd_in, abs_in, dvs_mag, sub, q_next, rem_next, q_fin, r_fin;
    logic [DATA_W:0] shifted;

    assign s_axis_dividend_tready = state == IDLE && !have_dvd;
    assign s_axis_divisor_tready  = state == IDLE && !have_dvs;
    assign m_axis_dout_tvalid     = state == DONE;
    assign dvd_hs = s_axis_dividend_tvalid && s_axis_dividend_tready;
    assign dvs_hs = s_axis_divisor_tvalid && s_axis_divisor_tready;
    assign start  = state == IDLE && (have_dvd || dvd_hs) && (have_dvs || dvs_hs);
    assign dvd_in = have_dvd ? dvd_r : s_axis_dividend_tdata;
    assign neg_in = SIGNED != 0 && dvd_in[DATA_W-1];
    assign abs_in = neg_in ? -dvd_in : dvd_in;
    assign last   = cnt == CW'(DATA_W - 1);

    // Iteration works on magnitudes; signs are reapplied only when the result is latched.
    assign neg_dvd  = SIGNED != 0 && dvd_r[DATA_W-1];
    assign neg_dvs  = SIGNED != 0 && dvs_r[DATA_W-1];
    assign dvs_mag  = neg_dvs ? -dvs_r : dvs_r;
    assign dvs_zero = dvs_r == '0;
    assign shifted  = {rem, q[DATA_W-1]};
    assign borrow   = shifted < {1'b0, dvs_mag};
    assign sub      = shifted[DATA_W-1:0] - dvs_mag;
    assign q_next   = {q[DATA_W-2:0], ~borrow};
    assign rem_next = borrow ? shifted[DATA_W-1:0] : sub;
    assign q_fin    = dvs_zero ? '1 : (neg_dvd ^ neg_dvs) ? -q_next : q_next;
    assign r_fin    = dvs_zero ? dvd_r : neg_dvd ? -rem_next : rem_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            have_dvd          <= 1'b0;
            have_dvs          <= 1'b0;
            dvd_r             <= '0;
            dvs_r             <= '0;
            q                 <= '0;
            rem               <= '0;
            cnt               <= '0;
            m_axis_dout_tdata <= '0;
        end else begin
            if (dvd_hs) dvd_r <= s_axis_dividend_tdata;
            if (dvs_hs) dvs_r <= s_axis_divisor_tdata;
            if (start) begin
                state    <= BUSY;
                have_dvd <= 1'b0;
                have_dvs <= 1'b0;
                q        <= abs_in;
                rem      <= '0;
                cnt      <= '0;
            end else begin
                if (dvd_hs) have_dvd <= 1'b1;
                if (dvs_hs) have_dvs <= 1'b1;
            end
            if (state == BUSY) begin
                q   <= q_next;
                rem <= rem_next;
                cnt <= cnt + 1'b1;
                if (last) begin
                    state             <= DONE;
                    m_axis_dout_tdata <= {q_fin, r_fin};
                end
            end
            if (state == DONE) state <= IDLE;
        end
    end
endmodule
